// File: rtl/pack_coalesce.sv
// Coalesces packed (thermometer-masked) lane beats into full N-lane output beats
// through a 2N-entry left-aligned staging buffer; a flush drains the remainder as a last beat.
module pack_coalesce #(
   parameter int N = 8,
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_vld,
   output logic           in_rdy,
   input  logic [N*W-1:0] in_w,
   input  logic [N-1:0]   in_vld_w,
   input  logic           in_flush,
   output logic           out_vld_r,
   input  logic           out_rdy,
   output logic [N*W-1:0] out_r,
   output logic [N-1:0]   out_vld_w_r,
   output logic           out_last_r,
   output logic           err_r
);

   localparam int OW = $clog2(2*N) + 1;
   localparam int KW = $clog2(N) + 1;

   logic [W-1:0]  stage_q [2*N];
   logic [W-1:0]  stage_d [2*N];
   logic [OW-1:0] occ;
   logic [OW-1:0] occ_d;
   logic [OW-1:0] pop_cnt;
   logic [OW-1:0] push_cnt;
   logic [OW-1:0] base;
   logic [KW-1:0] k;
   logic          flush_pend;
   logic          accept;
   logic          slot;
   logic          emit;
   logic          is_last;
   logic          bad_mask;

   assign in_rdy   = (occ <= OW'(N)) && !flush_pend;
   assign accept   = in_vld && in_rdy;
   assign slot     = !out_vld_r || out_rdy;
   assign emit     = slot && ((occ >= OW'(N)) || flush_pend);
   assign is_last  = flush_pend && (occ <= OW'(N));
   assign pop_cnt  = !emit ? '0 : ((occ < OW'(N)) ? occ : OW'(N));
   assign push_cnt = accept ? OW'(k) : '0;
   assign base     = occ - pop_cnt;
   assign occ_d    = base + push_cnt;
   assign bad_mask = (in_vld_w & (in_vld_w + N'(1))) != '0;

   always_comb begin
      k = '0;
      for (int j = 0; j < N; j++) k = k + KW'(in_vld_w[j]);
   end

   // Shift out the popped entries, then drop the accepted lanes in right behind the survivors
   always_comb begin
      for (int i = 0; i < 2*N; i++) begin
         stage_d[i] = stage_q[i];
         for (int s = 1; s <= N; s++)
            if (pop_cnt == OW'(s) && (i + s) < 2*N)
               stage_d[i] = stage_q[(i + s) % (2*N)];
         for (int j = 0; j < N; j++)
            if (OW'(j) < push_cnt && (base + OW'(j)) == OW'(i))
               stage_d[i] = in_w[j*W +: W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ         <= '0;
         flush_pend  <= 1'b0;
         out_vld_r   <= 1'b0;
         out_vld_w_r <= '0;
         out_last_r  <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         occ <= occ_d;
         if (accept && in_flush)
            flush_pend <= 1'b1;
         else if (emit && is_last)
            flush_pend <= 1'b0;
         if (accept && bad_mask)
            err_r <= 1'b1;
         if (emit) begin
            out_vld_r   <= 1'b1;
            out_vld_w_r <= ~({N{1'b1}} << pop_cnt);
            out_last_r  <= is_last;
         end else if (slot) begin
            out_vld_r <= 1'b0;
         end
      end
   end

   // Data path carries no reset; contents only matter under a set mask bit
   always_ff @(posedge clk) begin
      stage_q <= stage_d;
      if (emit)
         for (int i = 0; i < N; i++) out_r[i*W +: W] <= stage_q[i];
   end

endmodule

// File: tb/tb_pack_coalesce.sv
// Self-checking bench for pack_coalesce: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expected beats.
module tb_pack_coalesce;

   localparam int N = 8;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_vld;
   logic           in_rdy;
   logic [N*W-1:0] in_w;
   logic [N-1:0]   in_vld_w;
   logic           in_flush;
   logic           out_vld_r;
   logic           out_rdy;
   logic [N*W-1:0] out_r;
   logic [N-1:0]   out_vld_w_r;
   logic           out_last_r;
   logic           err_r;

   int pass_count  = 0;
   int check_count = 0;

   pack_coalesce #(.N(N), .W(W)) dut (
      .clk(clk), .rst(rst),
      .in_vld(in_vld), .in_rdy(in_rdy), .in_w(in_w), .in_vld_w(in_vld_w), .in_flush(in_flush),
      .out_vld_r(out_vld_r), .out_rdy(out_rdy), .out_r(out_r), .out_vld_w_r(out_vld_w_r),
      .out_last_r(out_last_r), .err_r(err_r)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_count++;
      if (act === exp) pass_count++;
      else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: entries live in a FIFO queue, beats are carved from its head
   int          mq[$];
   bit          m_fp = 0;
   logic        m_vld = 0;
   logic [N-1:0] m_mask = '0;
   logic        m_last = 0;
   logic        m_err = 0;
   logic [W-1:0] m_data [N];
   bit          model_valid = 0;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         m_fp = 0; m_vld = 0; m_mask = '0; m_last = 0; m_err = 0;
         model_valid = 1;
      end else begin
         automatic bit acc = in_vld && (mq.size() <= N) && !m_fp;
         if (!m_vld || out_rdy) begin
            if (mq.size() >= N || m_fp) begin
               automatic int p = (mq.size() < N) ? mq.size() : N;
               m_last = m_fp && (mq.size() <= N);
               for (int i = 0; i < p; i++) m_data[i] = W'(mq.pop_front());
               m_mask = N'((1 << p) - 1);
               m_vld = 1;
               if (m_last) m_fp = 0;
            end else begin
               m_vld = 0;
            end
         end
         if (acc) begin
            automatic int cnt = 0;
            for (int i = 0; i < N; i++) cnt += int'(in_vld_w[i]);
            if (int'(in_vld_w) != (1 << cnt) - 1) begin
               m_err = 1;
               model_valid = 0;
            end
            for (int i = 0; i < cnt; i++) mq.push_back(int'(in_w[i*W +: W]));
            if (in_flush) m_fp = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (model_valid && !rst) begin
         checkOutput("model_out_vld", 32'(out_vld_r), 32'(m_vld));
         checkOutput("model_in_rdy", 32'(in_rdy), 32'(mq.size() <= N && !m_fp));
         checkOutput("model_err", 32'(err_r), 32'(m_err));
         if (m_vld) begin
            checkOutput("model_mask", 32'(out_vld_w_r), 32'(m_mask));
            checkOutput("model_last", 32'(out_last_r), 32'(m_last));
            for (int i = 0; i < N; i++)
               if (m_mask[i]) checkOutput("model_lane", out_r[i*W +: W], m_data[i]);
         end
      end
   end

   task automatic applyStimulus(input logic [N-1:0] mask, input logic flush, input int base);
      int  cnt = 0;
      bit  done = 0;
      for (int i = 0; i < N; i++)
         in_w[i*W +: W] = mask[i] ? W'(base + i) : (32'hBAD00000 | 32'(i));
      in_vld_w = mask;
      in_flush = flush;
      in_vld   = 1'b1;
      while (!done && cnt < 50) begin
         @(negedge clk);
         done = in_rdy;
         @(posedge clk); #1;
         cnt++;
      end
      in_vld = 1'b0; in_flush = 1'b0; in_vld_w = '0;
      if (!done) checkOutput("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic waitBeat(input logic [N-1:0] mask, input logic last, input int base);
      int cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!out_vld_r && cnt < 50);
      if (!out_vld_r) begin
         checkOutput("beat_timeout", 32'd0, 32'd1);
      end else begin
         checkOutput("beat_mask", 32'(out_vld_w_r), 32'(mask));
         checkOutput("beat_last", 32'(out_last_r), 32'(last));
         for (int i = 0; i < N; i++)
            if (mask[i]) checkOutput("beat_lane", out_r[i*W +: W], W'(base + i));
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; in_vld = 1'b0; in_w = '0; in_vld_w = '0; in_flush = 1'b0; out_rdy = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_out_vld", 32'(out_vld_r), 32'd0);
      checkOutput("reset_mask", 32'(out_vld_w_r), 32'd0);
      checkOutput("reset_in_rdy", 32'(in_rdy), 32'd1);
      @(posedge clk); #1;

      // Three 3-lane beats coalesce into one full beat, one entry left over
      applyStimulus(8'h07, 1'b0, 0);
      applyStimulus(8'h07, 1'b0, 3);
      applyStimulus(8'h07, 1'b0, 6);
      waitBeat(8'hFF, 1'b0, 0);

      // Empty flush beat drains the leftover entry as a short last beat
      applyStimulus(8'h00, 1'b1, 0);
      @(negedge clk);
      checkOutput("flush_stall_in_rdy", 32'(in_rdy), 32'd0);
      waitBeat(8'h01, 1'b1, 8);
      @(negedge clk);
      checkOutput("flush_done_in_rdy", 32'(in_rdy), 32'd1);
      @(posedge clk); #1;

      // Backpressure fills the buffer to 2N, then everything drains in order
      out_rdy = 1'b0;
      applyStimulus(8'hFF, 1'b0, 0);
      applyStimulus(8'hFF, 1'b0, 8);
      applyStimulus(8'hFF, 1'b0, 16);
      @(negedge clk);
      checkOutput("full_in_rdy", 32'(in_rdy), 32'd0);
      checkOutput("held_out_vld", 32'(out_vld_r), 32'd1);
      @(posedge clk); #1 out_rdy = 1'b1;
      waitBeat(8'hFF, 1'b0, 0);
      waitBeat(8'hFF, 1'b0, 8);
      waitBeat(8'hFF, 1'b0, 16);

      // Flush on an empty buffer and flush with exactly N entries
      applyStimulus(8'h00, 1'b1, 0);
      waitBeat(8'h00, 1'b1, 0);
      applyStimulus(8'hFF, 1'b1, 500);
      waitBeat(8'hFF, 1'b1, 500);

      // Flush with N+5 entries: full non-last beat then a 5-lane last beat
      out_rdy = 1'b0;
      applyStimulus(8'hFF, 1'b0, 600);
      applyStimulus(8'hFF, 1'b0, 608);
      applyStimulus(8'h1F, 1'b1, 616);
      @(posedge clk); #1 out_rdy = 1'b1;
      waitBeat(8'hFF, 1'b0, 600);
      waitBeat(8'hFF, 1'b0, 608);
      waitBeat(8'h1F, 1'b1, 616);

      // Reset while a beat is held and 5 entries are buffered
      out_rdy = 1'b0;
      applyStimulus(8'hFF, 1'b0, 300);
      applyStimulus(8'h1F, 1'b0, 310);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_out_vld", 32'(out_vld_r), 32'd0);
      checkOutput("midrst_mask", 32'(out_vld_w_r), 32'd0);
      checkOutput("midrst_in_rdy", 32'(in_rdy), 32'd1);
      @(posedge clk); #1 out_rdy = 1'b1;
      applyStimulus(8'hFF, 1'b0, 400);
      waitBeat(8'hFF, 1'b0, 400);

      // Non-thermometer mask raises a sticky error cleared only by reset
      applyStimulus(8'h05, 1'b0, 700);
      @(negedge clk);
      checkOutput("err_set", 32'(err_r), 32'd1);
      repeat (3) @(negedge clk);
      checkOutput("err_sticky", 32'(err_r), 32'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("err_cleared", 32'(err_r), 32'd0);
      checkOutput("err_rst_in_rdy", 32'(in_rdy), 32'd1);

      repeat (2) @(posedge clk);
      $display("[TB] %0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
